mul_sequencer: RTL and testbench

Sequential 16×16 unsigned shift-add multiplier controller for the calculator datapath. It owns a single instance of the team's 16-bit carry-select adder (`carselec`) and drives it for 16 iterations to form a 32-bit product. Operands arrive and the product leaves through valid/ready handshakes. The block sits between the calculator's operand/opcode decode and its result register.

---
 rtl/calc_pkg.sv | 15 +
 rtl/carselec.sv | 34 +++
 rtl/mul_sequencer.sv | 107 ++++++++++
 tb/tb_mul_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operand width, multiply
// iteration count and the sequencer state encoding.
package calc_pkg;

  localparam int CALC_W   = 16;
  localparam int MUL_ITER = 16;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : calc_pkg

// File: rtl/carselec.sv
// 16-bit carry-select adder built from four 4-bit groups. Each upper group
// precomputes its sum for both possible carry-ins and the real carry picks one.
module carselec
  import calc_pkg::*;
(
  input  logic [CALC_W-1:0] a,
  input  logic [CALC_W-1:0] b,
  input  logic              c_in,
  output logic [CALC_W-1:0] sum,
  output logic              c_out
);

  localparam int GRP_W = 4;
  localparam int N_GRP = CALC_W / GRP_W;

  logic [N_GRP:0] carry;

  assign carry[0] = c_in;

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    logic [GRP_W:0] sum_c0;
    logic [GRP_W:0] sum_c1;

    assign sum_c0 = {1'b0, a[g*GRP_W +: GRP_W]} + {1'b0, b[g*GRP_W +: GRP_W]};
    assign sum_c1 = {1'b0, a[g*GRP_W +: GRP_W]} + {1'b0, b[g*GRP_W +: GRP_W]}
                    + {{GRP_W{1'b0}}, 1'b1};

    assign sum[g*GRP_W +: GRP_W] = carry[g] ? sum_c1[GRP_W-1:0] : sum_c0[GRP_W-1:0];
    assign carry[g+1]            = carry[g] ? sum_c1[GRP_W]     : sum_c0[GRP_W];
  end

  assign c_out = carry[N_GRP];

endmodule : carselec

// File: rtl/mul_sequencer.sv
// Sequential 16x16 unsigned shift-add multiplier. One carselec adder is reused
// for 16 iterations; operands and product move through valid/ready handshakes.
module mul_sequencer
  import calc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CALC_W-1:0]     a,
  input  logic [CALC_W-1:0]     b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*CALC_W-1:0]   product,
  output logic                  busy
);

  state_t             state, state_nxt;
  logic [CALC_W-1:0]  mcand, mcand_nxt;
  logic [CALC_W-1:0]  acc, acc_nxt;
  logic [CALC_W-1:0]  mplr, mplr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic [CALC_W-1:0]  add_sum;
  logic               add_cout;
  logic [CALC_W-1:0]  s_sel;
  logic               c_sel;

  carselec u_add (
    .a     (acc),
    .b     (mcand),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Operand mux: add the multiplicand only when the current multiplier bit is set
  always_comb begin
    s_sel = acc;
    c_sel = 1'b0;
    if (mplr[0]) begin
      s_sel = add_sum;
      c_sel = add_cout;
    end
  end

  // Next-state and datapath update for the sequencer FSM
  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    acc_nxt   = acc;
    mplr_nxt  = mplr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_nxt = a;
          mplr_nxt  = b;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Shift the {carry, sum, multiplier} chain right by one; the bit that
        // falls out of the sum becomes the next product bit in mplr.
        acc_nxt  = {c_sel, s_sel[CALC_W-1:1]};
        mplr_nxt = {s_sel[0], mplr[CALC_W-1:1]};
        cnt_nxt  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(MUL_ITER - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      acc   <= acc_nxt;
      mplr  <= mplr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign product   = {acc, mplr};

endmodule : mul_sequencer

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: table of single multiplies, then backpressure,
// mid-operation reset and back-to-back sequences, checked via a result queue.
module tb_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int unsigned total;
  int unsigned passed;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  mul_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
  endtask

  task automatic pop_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL %s: got 0x%08h, expected nothing (queue empty)", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // One complete multiply with out_ready already high; checks latency and busy
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [31:0] texp,
                        input string name);
    int n;
    logic busy_bad;
    @(negedge clk);
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    exp_q.push_back(texp);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    busy_bad = 1'b0;
    while (!out_valid && n < 40) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({name, " latency"}, n, 32'd16);
    check({name, " busy during run"}, {31'd0, busy_bad}, 32'd0);
    check({name, " busy in done"}, {31'd0, busy}, 32'd0);
    pop_check({name, " product"}, product);
    @(posedge clk);
    @(negedge clk);
    check({name, " idle in_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, " idle out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int cyc;
    int prev;
    int idx;
    int got;
    logic [15:0] b2b_a[3];
    logic [15:0] b2b_b[3];
    logic [31:0] b2b_e[3];

    total = 0; passed = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000};
    vecs[3] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vecs[4] = '{16'h00FF, 16'h0100, 32'h0000FF00};
    vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    vecs[6] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[7] = '{16'hABCD, 16'h1234, 32'h0C374FA4};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset product", product, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: hold the result for 5 cycles while offering new operands
    @(negedge clk);
    a = 16'h0101; b = 16'h0101; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    exp_q.push_back(32'h00010201);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("bp latency", n, 32'd16);
    for (int k = 0; k < 5; k++) begin
      a = 16'hFFFF; b = 16'h0002; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp hold out_valid %0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp hold product %0d", k), product, 32'h00010201);
      check($sformatf("bp hold in_ready %0d", k), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    pop_check("bp product", product);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp released in_ready", {31'd0, in_ready}, 32'd1);
    check("bp released out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp no stray accept", {31'd0, busy}, 32'd0);

    // Reset at iteration 8 drops the in-flight multiply
    a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(32'h06260060);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("mid busy before reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset product", product, 32'd0);
    run_op(16'd7, 16'd9, 32'd63, "after reset");

    // Back-to-back with in_valid and out_ready held high
    b2b_a[0] = 16'h0003; b2b_b[0] = 16'h0005; b2b_e[0] = 32'h0000000F;
    b2b_a[1] = 16'hFFFF; b2b_b[1] = 16'hFFFF; b2b_e[1] = 32'hFFFE0001;
    b2b_a[2] = 16'hABCD; b2b_b[2] = 16'h1234; b2b_e[2] = 32'h0C374FA4;
    out_ready = 1'b1;
    cyc = 0; prev = -1; idx = 0; got = 0;
    while (got < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        pop_check($sformatf("b2b product %0d", got), product);
        if (prev >= 0) check($sformatf("b2b spacing %0d", got), cyc - prev, 32'd18);
        prev = cyc;
        got++;
      end
      if (in_ready) begin
        if (idx < 3) begin
          a = b2b_a[idx]; b = b2b_b[idx]; in_valid = 1'b1;
          exp_q.push_back(b2b_e[idx]);
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
    end
    in_valid = 1'b0;
    check("b2b result count", got, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mul_sequencer
